// File: rtl/mem_write_checker.sv
// In-order store-sequence checker for the core data-memory port.
// Build option: define MWC_IGNORE_EN to filter stores to IGNORE_ADDR.
module mem_write_checker #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_EXP     = 4,
    parameter int IGNORE_ADDR = 96,
    parameter int TIMEOUT     = 1000,
    parameter int CNT_W       = 16,
    localparam int IDX_W = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1,
    localparam int MC_W  = $clog2(NUM_EXP + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] data_adr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              exp_wr_en,
    input  logic [IDX_W-1:0]  exp_wr_idx,
    input  logic [ADDR_W-1:0] exp_wr_adr,
    input  logic [DATA_W-1:0] exp_wr_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [MC_W-1:0]   match_cnt,
    output logic [CNT_W-1:0]  cycle_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] PASS = 2'd2;
    localparam logic [1:0] FAIL = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] exp_adr  [NUM_EXP];
    logic [DATA_W-1:0] exp_data [NUM_EXP];

    logic [IDX_W-1:0]  cur_idx;
    logic              filt;
    logic              st;
    logic              adr_eq;
    logic              dat_eq;
    logic              hit;
    logic              last;
    logic              tmo;
    logic [CNT_W-1:0]  cnt_inc;

    // Table is deliberately not reset so it survives a reset between runs.
    always_ff @(posedge clk) begin
        if (exp_wr_en && (32'(exp_wr_idx) < NUM_EXP)) begin
            exp_adr[exp_wr_idx]  <= exp_wr_adr;
            exp_data[exp_wr_idx] <= exp_wr_data;
        end
    end

`ifdef MWC_IGNORE_EN
    assign filt = (data_adr == ADDR_W'(IGNORE_ADDR));
`else
    assign filt = 1'b0;
`endif

    assign cur_idx = match_cnt[IDX_W-1:0];
    assign st      = mem_write && !filt;
    assign adr_eq  = (data_adr == exp_adr[cur_idx]);
    assign dat_eq  = (write_data == exp_data[cur_idx]);
    assign hit     = st && adr_eq && dat_eq;
    assign last    = (32'(match_cnt) == NUM_EXP - 1);
    assign tmo     = (cycle_cnt == CNT_W'(TIMEOUT - 1));
    assign cnt_inc = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            match_cnt <= '0;
            cycle_cnt <= '0;
            fail_code <= 2'b00;
        end else if (start) begin
            state     <= RUN;
            match_cnt <= '0;
            cycle_cnt <= '0;
            fail_code <= 2'b00;
        end else if (state == RUN) begin
            cycle_cnt <= cnt_inc;
            // A final match outranks a timeout on the same edge.
            if (hit && last) begin
                state     <= PASS;
                match_cnt <= match_cnt + MC_W'(1);
            end else if (st && !adr_eq) begin
                state     <= FAIL;
                fail_code <= 2'b01;
            end else if (st && !dat_eq) begin
                state     <= FAIL;
                fail_code <= 2'b10;
            end else begin
                if (hit) match_cnt <= match_cnt + MC_W'(1);
                if (tmo) begin
                    state     <= FAIL;
                    fail_code <= 2'b11;
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign pass = (state == PASS);
    assign fail = (state == FAIL);
    assign done = pass || fail;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: one 1-entry/20-cycle-timeout
// instance and one 4-entry instance sharing the store bus.
module tb_mem_write_checker;

    logic        clk;
    logic        reset;
    logic        mem_write;
    logic [31:0] data_adr;
    logic [31:0] write_data;

    logic        a_start, a_wr_en;
    logic [0:0]  a_wr_idx;
    logic [31:0] a_wr_adr, a_wr_data;
    logic        a_busy, a_done, a_pass, a_fail;
    logic [1:0]  a_code;
    logic [0:0]  a_match;
    logic [15:0] a_cyc;

    logic        b_start, b_wr_en;
    logic [1:0]  b_wr_idx;
    logic [31:0] b_wr_adr, b_wr_data;
    logic        b_busy, b_done, b_pass, b_fail;
    logic [1:0]  b_code;
    logic [2:0]  b_match;
    logic [15:0] b_cyc;

    int n_chk;
    int n_fail;

    mem_write_checker #(
        .NUM_EXP(1), .TIMEOUT(20)
    ) dut_a (
        .clk(clk), .reset(reset), .start(a_start),
        .mem_write(mem_write), .data_adr(data_adr),
        .write_data(write_data),
        .exp_wr_en(a_wr_en), .exp_wr_idx(a_wr_idx),
        .exp_wr_adr(a_wr_adr), .exp_wr_data(a_wr_data),
        .busy(a_busy), .done(a_done), .pass(a_pass),
        .fail(a_fail), .fail_code(a_code),
        .match_cnt(a_match), .cycle_cnt(a_cyc)
    );

    mem_write_checker #(
        .NUM_EXP(4), .TIMEOUT(1000)
    ) dut_b (
        .clk(clk), .reset(reset), .start(b_start),
        .mem_write(mem_write), .data_adr(data_adr),
        .write_data(write_data),
        .exp_wr_en(b_wr_en), .exp_wr_idx(b_wr_idx),
        .exp_wr_adr(b_wr_adr), .exp_wr_data(b_wr_data),
        .busy(b_busy), .done(b_done), .pass(b_pass),
        .fail(b_fail), .fail_code(b_code),
        .match_cnt(b_match), .cycle_cnt(b_cyc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mem_write  = 1'b1;
        data_adr   = a;
        write_data = d;
        @(negedge clk);
        mem_write  = 1'b0;
    endtask

    task automatic start_a();
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic start_b();
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
    endtask

    task automatic wr_a(input logic [0:0] i, input logic [31:0] a,
                        input logic [31:0] d);
        a_wr_en = 1'b1; a_wr_idx = i; a_wr_adr = a; a_wr_data = d;
        @(negedge clk);
        a_wr_en = 1'b0;
    endtask

    task automatic wr_b(input logic [1:0] i, input logic [31:0] a,
                        input logic [31:0] d);
        b_wr_en = 1'b1; b_wr_idx = i; b_wr_adr = a; b_wr_data = d;
        @(negedge clk);
        b_wr_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0;
        reset = 1'b0; mem_write = 1'b0; data_adr = '0; write_data = '0;
        a_start = 1'b0; a_wr_en = 1'b0; a_wr_idx = '0;
        a_wr_adr = '0; a_wr_data = '0;
        b_start = 1'b0; b_wr_en = 1'b0; b_wr_idx = '0;
        b_wr_adr = '0; b_wr_data = '0;

        #2;
        check("rst_busy", 32'(a_busy), 0);
        check("rst_done", 32'(a_done), 0);
        check("rst_pass", 32'(a_pass), 0);
        check("rst_fail", 32'(a_fail), 0);
        check("rst_code", 32'(a_code), 0);
        check("rst_match", 32'(a_match), 0);
        check("rst_cyc", 32'(a_cyc), 0);
        @(negedge clk);
        reset = 1'b1;

        wr_a(1'b0, 100, 25);

        // store sequence with scratch store ahead of the real one
        start_a();
        check("t1_busy", 32'(a_busy), 1);
        check("t1_cyc0", 32'(a_cyc), 0);
`ifdef MWC_IGNORE_EN
        store(96, 7);
        check("t1_filt_busy", 32'(a_busy), 1);
        check("t1_filt_match", 32'(a_match), 0);
`else
        store(96, 7);
        check("t3_nofilt_fail", 32'(a_fail), 1);
        check("t3_nofilt_code", 32'(a_code), 1);
        start_a();
`endif
        check("t1_pre_pass", 32'(a_pass), 0);
        store(100, 25);
        check("t1_pass", 32'(a_pass), 1);
        check("t1_done", 32'(a_done), 1);
        check("t1_code", 32'(a_code), 0);
        check("t1_match", 32'(a_match), 1);
        check("t1_busy_lo", 32'(a_busy), 0);

        // data mismatch
        start_a();
        check("t2_rearm_match", 32'(a_match), 0);
        check("t2_rearm_code", 32'(a_code), 0);
        store(100, 24);
        check("t2_fail", 32'(a_fail), 1);
        check("t2_code", 32'(a_code), 2);
        check("t2_match", 32'(a_match), 0);

        // address mismatch
        start_a();
        store(104, 25);
        check("t3_fail", 32'(a_fail), 1);
        check("t3_code", 32'(a_code), 1);

        // timeout with no stores
        start_a();
        repeat (19) @(negedge clk);
        check("t4_cyc19", 32'(a_cyc), 19);
        check("t4_busy19", 32'(a_busy), 1);
        @(negedge clk);
        check("t4_busy_lo", 32'(a_busy), 0);
        check("t4_fail", 32'(a_fail), 1);
        check("t4_code", 32'(a_code), 3);

        // final match on the timeout edge
        start_a();
        repeat (19) @(negedge clk);
        store(100, 25);
        check("t6_pass", 32'(a_pass), 1);
        check("t6_fail", 32'(a_fail), 0);
        check("t6_code", 32'(a_code), 0);
        store(100, 25);
        check("t6_sticky_match", 32'(a_match), 1);
        store(104, 25);
        check("t6_sticky_pass", 32'(a_pass), 1);
        check("t6_sticky_fail", 32'(a_fail), 0);

        // four-entry sequence
        wr_b(2'd0, 0, 1);
        wr_b(2'd1, 4, 2);
        wr_b(2'd2, 8, 3);
        wr_b(2'd3, 12, 4);
        start_b();
        store(0, 1);
        check("t5_m1", 32'(b_match), 1);
        store(4, 2);
        check("t5_m2", 32'(b_match), 2);
        store(8, 3);
        check("t5_m3", 32'(b_match), 3);
        check("t5_busy3", 32'(b_busy), 1);
        store(12, 4);
        check("t5_m4", 32'(b_match), 4);
        check("t5_pass", 32'(b_pass), 1);
        check("t5_cyc4", 32'(b_cyc), 4);

        start_b();
        check("t5_re_match", 32'(b_match), 0);
        check("t5_re_cyc", 32'(b_cyc), 0);
        check("t5_re_busy", 32'(b_busy), 1);
        check("t5_re_pass", 32'(b_pass), 0);
        repeat (3) @(negedge clk);
        check("t5_cyc3", 32'(b_cyc), 3);
        store(0, 1);
        check("t5_mid_match", 32'(b_match), 1);

        // asynchronous reset mid-RUN, away from any clock edge
        #2 reset = 1'b0;
        #1;
        check("t5_arst_busy", 32'(b_busy), 0);
        check("t5_arst_match", 32'(b_match), 0);
        check("t5_arst_cyc", 32'(b_cyc), 0);
        check("t5_arst_done", 32'(b_done), 0);
        check("t5_arst_a_pass", 32'(a_pass), 0);
        @(negedge clk);
        reset = 1'b1;

        // table survives reset
        start_b();
        store(0, 1);
        check("t5_keep_match", 32'(b_match), 1);
        store(8, 3);
        check("t5_order_fail", 32'(b_fail), 1);
        check("t5_order_code", 32'(b_code), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
